// File: rtl/ripple_count_capture.sv
// Synchronises, de-glitches and extends a narrow asynchronous ripple count into a wide
// running total with a valid/ready output. Optional macro CAPTURE_OVF_EN adds a sticky overflow flag.
module ripple_count_capture #(
    parameter int unsigned CNT_W         = 4,
    parameter int unsigned EXT_W         = 16,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cnt_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [EXT_W-1:0] out_total,
    output logic             settled,
    output logic             ovf
);

    localparam int unsigned RUN_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

    typedef enum logic {
        ST_INIT,
        ST_TRACK
    } state_e;

    logic [CNT_W-1:0] sync_q [SYNC_STAGES];
    logic [CNT_W-1:0] s_c, s_nxt_c, diff_c;
    logic [EXT_W-1:0] delta_c, sum_c;
    logic             accept_c, xfer_c;

    state_e           state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] base_q, base_d;
    logic [EXT_W-1:0] total_q, total_d;
    logic [EXT_W-1:0] out_total_q, out_total_d;
    logic             out_valid_q, out_valid_d;
    logic             pend_q, pend_d;
    logic             settled_q, settled_d;

    // Per-bit synchroniser chain; s_nxt_c is the sample that becomes s on the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= cnt_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s_c     = sync_q[SYNC_STAGES-1];
    assign s_nxt_c = sync_q[SYNC_STAGES-2];
    assign xfer_c  = out_valid_q && out_ready;

    // Accept only on the transition into saturation, and only for a value differing from baseline.
    assign accept_c = (s_nxt_c == s_c) && (run_q == RUN_MAX - RUN_W'(1)) && (s_c != base_q);
    assign diff_c   = s_c - base_q;
    assign delta_c  = {{(EXT_W - CNT_W){1'b0}}, diff_c};

`ifdef CAPTURE_OVF_EN
    logic [EXT_W:0] wide_sum_c;
    logic           ovf_q, ovf_d;

    assign wide_sum_c = {1'b0, total_q} + {1'b0, delta_c};
    assign sum_c      = wide_sum_c[EXT_W-1:0];

    always_comb begin
        ovf_d = ovf_q;
        if (accept_c && state_q == ST_TRACK && wide_sum_c[EXT_W]) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`else
    assign sum_c = total_q + delta_c;
    assign ovf   = 1'b0;
`endif

    always_comb begin
        if (s_nxt_c != s_c)      run_d = '0;
        else if (run_q == RUN_MAX) run_d = run_q;
        else                     run_d = run_q + RUN_W'(1);
    end

    // Next-state, total update and output handshake.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        total_d     = total_q;
        out_total_d = out_total_q;
        out_valid_d = out_valid_q;
        pend_d      = pend_q;
        settled_d   = 1'b0;

        if (xfer_c) begin
            out_valid_d = pend_q;
            out_total_d = total_q;
            pend_d      = 1'b0;
        end

        case (state_q)
            ST_INIT: begin
                if (accept_c) begin
                    base_d    = s_c;
                    state_d   = ST_TRACK;
                    settled_d = 1'b1;
                end
            end
            ST_TRACK: begin
                if (accept_c) begin
                    total_d   = sum_c;
                    base_d    = s_c;
                    settled_d = 1'b1;
                    if (!out_valid_q || xfer_c) begin
                        out_valid_d = 1'b1;
                        out_total_d = sum_c;
                        pend_d      = 1'b0;
                    end else begin
                        pend_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            run_q       <= '0;
            base_q      <= '0;
            total_q     <= '0;
            out_total_q <= '0;
            out_valid_q <= 1'b0;
            pend_q      <= 1'b0;
            settled_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            base_q      <= base_d;
            total_q     <= total_d;
            out_total_q <= out_total_d;
            out_valid_q <= out_valid_d;
            pend_q      <= pend_d;
            settled_q   <= settled_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_total = out_total_q;
    assign settled   = settled_q;

endmodule

// File: tb/tb_ripple_count_capture.sv
// Directed bench for ripple_count_capture (default parameters, CAPTURE_OVF_EN undefined).
module tb_ripple_count_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  cnt_in;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out_total;
    logic        settled;
    logic        ovf;

    int n_cmp = 0;
    int n_err = 0;

    ripple_count_capture dut (
        .clk       (clk),
        .rst       (rst),
        .cnt_in    (cnt_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_total (out_total),
        .settled   (settled),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive a value and hold it long enough to be accepted and drained.
    task automatic apply(input logic [3:0] v);
        cnt_in = v;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int n_set, n_val;
        logic [3:0] walk [6];
        walk = '{4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd14};

        rst = 1'b1; cnt_in = 4'd0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_total", 32'(out_total), 0);
        chk("rst_settled", 32'(settled), 0);
        rst = 1'b0;

        // Count equal to reset baseline: nothing accepted
        repeat (8) @(negedge clk);
        chk("idle_valid", 32'(out_valid), 0);
        chk("idle_settled", 32'(settled), 0);

        // First accept sets baseline 10, no output beat
        cnt_in = 4'd10; n_set = 0; n_val = 0;
        repeat (8) begin
            @(negedge clk);
            if (settled) n_set++;
            if (out_valid) n_val++;
        end
        chk("init_settled_cnt", 32'(n_set), 1);
        chk("init_valid_cnt", 32'(n_val), 0);

        // 10 -> 0 wraps: delta 6
        cnt_in = 4'd0;
        repeat (5) @(negedge clk);
        chk("c0_valid", 32'(out_valid), 1);
        chk("c0_total", 32'(out_total), 6);
        @(negedge clk);
        chk("c0_drained", 32'(out_valid), 0);

        // Latency: settled exactly 5 edges after the sampling edge
        cnt_in = 4'd5; n_set = 0;
        repeat (4) begin
            @(negedge clk);
            if (settled) n_set++;
        end
        chk("lat_early", 32'(n_set), 0);
        @(negedge clk);
        chk("lat_settled", 32'(settled), 1);
        chk("lat_valid", 32'(out_valid), 1);
        chk("lat_total", 32'(out_total), 11);
        @(negedge clk);
        chk("lat_pulse", 32'(settled), 0);

        // Glitch: 7 accepted, brief 6 rejected, 8 accepted
        apply(4'd7);
        chk("g7_total", 32'(out_total), 13);
        cnt_in = 4'd6; n_set = 0;
        repeat (2) begin
            @(negedge clk);
            if (settled) n_set++;
        end
        cnt_in = 4'd8;
        repeat (8) begin
            @(negedge clk);
            if (settled) n_set++;
        end
        chk("glitch_settled_cnt", 32'(n_set), 1);
        chk("glitch_total", 32'(out_total), 14);

        // Walk the total to 100 with baseline 14, then wrap 14 -> 2
        for (int i = 0; i < 6; i++) apply(walk[i]);
        chk("walk_total", 32'(out_total), 100);
        apply(4'd2);
        chk("wrap_total", 32'(out_total), 104);
        apply(4'd0);
        chk("b0_total", 32'(out_total), 118);

        // Backpressure: first beat held, later accept pending
        out_ready = 1'b0;
        cnt_in = 4'd3;
        repeat (5) @(negedge clk);
        chk("bp1_valid", 32'(out_valid), 1);
        chk("bp1_total", 32'(out_total), 121);
        cnt_in = 4'd5;
        repeat (6) @(negedge clk);
        chk("bp_frozen", 32'(out_total), 121);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp2_valid", 32'(out_valid), 1);
        chk("bp2_total", 32'(out_total), 123);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_empty", 32'(out_valid), 0);

        // Accept coincident with transfer
        cnt_in = 4'd9;
        repeat (5) @(negedge clk);
        chk("m1_total", 32'(out_total), 127);
        cnt_in = 4'd11;
        repeat (4) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        chk("merge_valid", 32'(out_valid), 1);
        chk("merge_total", 32'(out_total), 129);
        @(negedge clk);
        chk("merge_drained", 32'(out_valid), 0);
        out_ready = 1'b0;

        // Asynchronous reset with a beat pending
        cnt_in = 4'd13;
        repeat (5) @(negedge clk);
        chk("pre_rst_valid", 32'(out_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_total", 32'(out_total), 0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        n_set = 0; n_val = 0;
        repeat (8) begin
            @(negedge clk);
            if (settled) n_set++;
            if (out_valid) n_val++;
        end
        chk("post_rst_settled", 32'(n_set), 1);
        chk("post_rst_valid", 32'(n_val), 0);
        apply(4'd15);
        chk("post_rst_total", 32'(out_total), 2);
        chk("ovf_off", 32'(ovf), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
